md5_padder: RTL and testbench



---
 rtl/md5_pkg.sv | 49 ++++
 rtl/md5_padder.sv | 160 ++++++++++++++++
 tb/tb_md5_padder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared types and byte-placement helpers for the MD5 message padder.
package md5_pkg;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SEND  = 2'd1,
        EXTRA = 2'd2
    } md5_state_e;

    // Replace byte `pos` of a block; byte 0 sits at [511:504].
    function automatic logic [511:0] put_byte(input logic [511:0] blk,
                                              input logic [5:0]   pos,
                                              input logic [7:0]   b);
        logic [511:0] r;
        r = blk;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (pos == 6'(k)) r[511-8*k -: 8] = b;
        end
        return r;
    endfunction

    // Replace 32-bit word `idx` of a block; word 0 sits at [511:480].
    function automatic logic [511:0] put_word(input logic [511:0] blk,
                                              input logic [3:0]   idx,
                                              input logic [31:0]  w);
        logic [511:0] r;
        r = blk;
        for (int j = 0; j < 16; j++) begin
            if (idx == 4'(j)) r[511-32*j -: 32] = w;
        end
        return r;
    endfunction

    // Write the 64-bit bit count little-endian into bytes 56..63.
    function automatic logic [511:0] put_len(input logic [511:0] blk,
                                             input logic [63:0]  len);
        logic [511:0] r;
        r = blk;
        for (int i = 0; i < 8; i++) begin
            r[511-8*(LEN_OFFSET+i) -: 8] = len[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/md5_padder.sv
// Packs a 32-bit word stream into RFC 1321 padded 512-bit blocks for the MD5 core.
//
// Both ports use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; while valid is high without ready, the payload and
// its side-band (last, nbytes / first, last) are held unchanged.
module md5_padder
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output md5_state_e   dbg_state
);

    md5_state_e         state_q, state_d;
    logic [511:0]       blk_q, blk_d;
    logic [3:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               need_80_q, need_80_d;
    logic               need_len_q, need_len_d;
    logic               final_q, final_d;
    // Set once a block of the current message has gone out, so later blocks are not "first".
    logic               started_q, started_d;
    logic               in_ready_q;

    logic               accept;
    logic [2:0]         nb;
    logic [31:0]        keep_mask;
    logic [6:0]         p;
    logic [LEN_W-1:0]   len_acc;
    logic [511:0]       blk_tmp;

    assign accept = in_valid & in_ready_q;

    // State and datapath registers; reset drops any partial or pending block.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= FILL;
            blk_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            need_80_q  <= 1'b0;
            need_len_q <= 1'b0;
            final_q    <= 1'b0;
            started_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            need_80_q  <= need_80_d;
            need_len_q <= need_len_d;
            final_q    <= final_d;
            started_q  <= started_d;
            in_ready_q <= (state_d == FILL);
        end
    end

    // Next state: word capture, pad/length insertion and block turnover.
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        idx_d      = idx_q;
        len_d      = len_q;
        need_80_d  = need_80_q;
        need_len_d = need_len_q;
        final_d    = final_q;
        started_d  = started_q;
        blk_tmp    = blk_q;

        // Byte counts above 4 are treated as a full word.
        nb = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        case (nb)
            3'd0:    keep_mask = 32'h0000_0000;
            3'd1:    keep_mask = 32'hFF00_0000;
            3'd2:    keep_mask = 32'hFFFF_0000;
            3'd3:    keep_mask = 32'hFFFF_FF00;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase
        // Byte offset just past the last valid byte of the closing word.
        p       = {1'b0, idx_q, 2'b00} + {4'b0000, nb};
        len_acc = len_q + (in_last ? LEN_W'({nb, 3'b000}) : LEN_W'(32));

        case (state_q)
            FILL: begin
                if (accept) begin
                    len_d = len_acc;
                    idx_d = idx_q + 4'd1;
                    if (!in_last) begin
                        blk_d = put_word(blk_q, idx_q, in_data);
                        if (idx_q == 4'd15) begin
                            final_d = 1'b0;
                            state_d = SEND;
                        end
                    end else begin
                        blk_tmp = put_word(blk_q, idx_q, in_data & keep_mask);
                        if (p < 7'd64) blk_tmp = put_byte(blk_tmp, p[5:0], PAD_BYTE);
                        if (p <= 7'd55) begin
                            blk_tmp = put_len(blk_tmp, 64'(len_acc));
                            final_d = 1'b1;
                        end else begin
                            // No room for the length: it moves to an extra block.
                            final_d    = 1'b0;
                            need_len_d = 1'b1;
                            need_80_d  = (p == 7'd64);
                        end
                        blk_d   = blk_tmp;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (blk_ready) begin
                    blk_d = '0;
                    idx_d = '0;
                    if (final_q) begin
                        len_d     = '0;
                        started_d = 1'b0;
                    end else begin
                        started_d = 1'b1;
                    end
                    state_d = need_len_q ? EXTRA : FILL;
                end
            end
            EXTRA: begin
                blk_tmp = '0;
                if (need_80_q) blk_tmp = put_byte(blk_tmp, 6'd0, PAD_BYTE);
                blk_d      = put_len(blk_tmp, 64'(len_q));
                need_80_d  = 1'b0;
                need_len_d = 1'b0;
                final_d    = 1'b1;
                state_d    = SEND;
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        in_ready  = in_ready_q;
        blk_valid = (state_q == SEND);
        blk_data  = blk_q;
        blk_first = (state_q == SEND) & ~started_q;
        blk_last  = (state_q == SEND) & final_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder: single-word vector table plus multi-block sequences.
module tb_md5_padder;
    import md5_pkg::*;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    md5_state_e   dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [511:0] exp_q[$];

    md5_padder #(.LEN_W(64)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_nbytes(in_nbytes),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data (blk_data),
        .blk_first(blk_first),
        .blk_last (blk_last),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one word and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbytes = nbytes;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        if (!in_ready) check1("send_word_timeout", 64'(in_ready), 64'd1);
        @(posedge wb_clk_i); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Accept one block and compare it against the head of the expected queue.
    task automatic get_block(input string name, input logic exp_first, input logic exp_last);
        int n;
        logic [511:0] e;
        blk_ready = 1'b1;
        n = 0;
        while (!blk_valid && n < 100) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check1({name, "_valid"}, 64'(blk_valid), 64'd1);
        check_blk({name, "_data"}, blk_data, e);
        check1({name, "_first"}, 64'(blk_first), 64'(exp_first));
        check1({name, "_last"}, 64'(blk_last), 64'(exp_last));
        @(posedge wb_clk_i); #1;
        blk_ready = 1'b0;
    endtask

    function automatic logic [31:0] seq_word(input int i);
        return {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
    endfunction

    typedef struct {
        string        name;
        logic         has_pre;
        logic [31:0]  pre_word;
        logic [31:0]  last_word;
        logic [2:0]   nbytes;
        logic [511:0] exp_blk;
    } vec_t;

    vec_t vecs[7];
    logic [511:0] abc_blk;
    logic [511:0] e;
    logic [511:0] held;

    initial begin
        abc_blk = {32'h61626380, 416'h0, 8'h18, 56'h0};
        vecs[0] = '{"empty",   1'b0, 32'h0,        32'hDEADBEEF, 3'd0, {8'h80, 504'h0}};
        vecs[1] = '{"abc",     1'b0, 32'h0,        32'h61626300, 3'd3, abc_blk};
        vecs[2] = '{"one_b",   1'b0, 32'h0,        32'hABFFFFFF, 3'd1, {32'hAB800000, 416'h0, 8'h08, 56'h0}};
        vecs[3] = '{"two_b",   1'b0, 32'h0,        32'h12345555, 3'd2, {32'h12348000, 416'h0, 8'h10, 56'h0}};
        vecs[4] = '{"four_b",  1'b0, 32'h0,        32'hCAFEBABE, 3'd4, {32'hCAFEBABE, 8'h80, 408'h0, 8'h20, 56'h0}};
        vecs[5] = '{"pre_nb0", 1'b1, 32'h11223344, 32'h99999999, 3'd0, {32'h11223344, 32'h80000000, 384'h0, 8'h20, 56'h0}};
        vecs[6] = '{"pre_nb3", 1'b1, 32'h11223344, 32'h55667788, 3'd3, {32'h11223344, 32'h55667780, 384'h0, 8'h38, 56'h0}};

        // Reset values
        repeat (3) @(posedge wb_clk_i);
        #1;
        check1("rst_in_ready", 64'(in_ready), 64'd0);
        check1("rst_blk_valid", 64'(blk_valid), 64'd0);
        check1("rst_blk_first", 64'(blk_first), 64'd0);
        check1("rst_blk_last", 64'(blk_last), 64'd0);
        check_blk("rst_blk_data", blk_data, '0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        check1("in_ready_rise", 64'(in_ready), 64'd1);

        // Single-block vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].has_pre) send_word(vecs[i].pre_word, 1'b0, 3'd0);
            send_word(vecs[i].last_word, 1'b1, vecs[i].nbytes);
            check1({vecs[i].name, "_latency"}, 64'(blk_valid), 64'd1);
            exp_q.push_back(vecs[i].exp_blk);
            get_block(vecs[i].name, 1'b1, 1'b1);
        end

        // 56-byte message: pad byte fits, length spills into an extra block
        e = '0;
        for (int k = 0; k < 56; k++) e[511-8*k -: 8] = 8'(k+1);
        e[511-8*56 -: 8] = 8'h80;
        exp_q.push_back(e);
        e = '0;
        e[511-8*56 -: 8] = 8'hC0;
        e[511-8*57 -: 8] = 8'h01;
        exp_q.push_back(e);
        for (int i = 0; i < 14; i++) send_word(seq_word(i), (i == 13), 3'd4);
        get_block("m56_b1", 1'b1, 1'b0);
        check1("m56_extra_in_ready", 64'(in_ready), 64'd0);
        check1("m56_extra_blk_valid", 64'(blk_valid), 64'd0);
        get_block("m56_b2", 1'b0, 1'b1);

        // 64-byte message ending on a full last word
        e = '0;
        for (int k = 0; k < 64; k++) e[511-8*k -: 8] = 8'(k+1);
        exp_q.push_back(e);
        e = '0;
        e[511 -: 8] = 8'h80;
        e[511-8*57 -: 8] = 8'h02;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) send_word(seq_word(i), (i == 15), 3'd4);
        get_block("m64_b1", 1'b1, 1'b0);
        get_block("m64_b2", 1'b0, 1'b1);

        // 64 bytes sent as 16 plain words, then an empty closing word
        exp_q.push_back(exp_q.size() == 0 ? '0 : '0);
        exp_q.pop_back();
        e = '0;
        for (int k = 0; k < 64; k++) e[511-8*k -: 8] = 8'(k+1);
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) send_word(seq_word(i), 1'b0, 3'd0);
        get_block("m64f_b1", 1'b1, 1'b0);
        e = '0;
        e[511 -: 8] = 8'h80;
        e[511-8*57 -: 8] = 8'h02;
        exp_q.push_back(e);
        send_word(32'hFFFFFFFF, 1'b1, 3'd0);
        get_block("m64f_b2", 1'b0, 1'b1);

        // Backpressure: block held for 10 cycles while the next word waits
        send_word(32'h61626300, 1'b1, 3'd3);
        held = blk_data;
        check_blk("bp_first_data", held, abc_blk);
        in_valid  = 1'b1;
        in_data   = 32'h64650000;
        in_last   = 1'b1;
        in_nbytes = 3'd2;
        for (int c = 0; c < 10; c++) begin
            @(posedge wb_clk_i); #1;
            check1("bp_valid", 64'(blk_valid), 64'd1);
            check_blk("bp_data", blk_data, abc_blk);
            check1("bp_in_ready", 64'(in_ready), 64'd0);
        end
        exp_q.push_back(abc_blk);
        get_block("bp_abc", 1'b1, 1'b1);
        // FILL resumes now; the held word is taken on this edge
        check1("bp_resume_in_ready", 64'(in_ready), 64'd1);
        @(posedge wb_clk_i); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.push_back({32'h64658000, 416'h0, 8'h10, 56'h0});
        get_block("bp_de", 1'b1, 1'b1);

        // Reset after 7 words discards the partial message
        for (int i = 0; i < 7; i++) send_word(seq_word(i), 1'b0, 3'd0);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check1("rst_mid_blk_valid", 64'(blk_valid), 64'd0);
        check1("rst_mid_in_ready", 64'(in_ready), 64'd0);
        wb_rst_i = 1'b0;
        exp_q.push_back(abc_blk);
        send_word(32'h61626300, 1'b1, 3'd3);
        get_block("rst_mid_abc", 1'b1, 1'b1);

        // Reset while a block is pending
        send_word(32'hCAFEBABE, 1'b1, 3'd4);
        check1("rst_send_pending", 64'(blk_valid), 64'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check1("rst_send_blk_valid", 64'(blk_valid), 64'd0);
        check_blk("rst_send_blk_data", blk_data, '0);
        wb_rst_i = 1'b0;
        exp_q.push_back(abc_blk);
        send_word(32'h61626300, 1'b1, 3'd3);
        get_block("rst_send_abc", 1'b1, 1'b1);

        check1("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
